micro_waves_control: RTL and testbench

- Digital microwave-oven controller.
- Cook time is entered on a one-hot 10-key keypad as M:SS and counts down once per second while cooking.
- Drives the magnetron enable and three 7-segment digits (minutes, seconds tens, seconds ones).
- Top-level control block, fed by debounced, clock-synchronous front-panel signals.

---
 rtl/micro_waves_control_if.sv | 36 +++
 rtl/micro_waves_control.sv | 146 ++++++++++++++
 tb/tb_micro_waves_control.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/micro_waves_control_if.sv
`default_nettype none
// ============================================================================
// Module      : micro_waves_control_if
// Description : Front-panel bundle for the microwave controller. The panel
//               side (master) drives buttons, door switch and keypad; the
//               controller side (slave) drives the three digit displays and
//               the magnetron enable.
//   startn/stopn/clearn : active-low buttons
//   door_closed         : 1 = door closed
//   keypad[9:0]         : one-hot digit keys, active-high
//   *_segs[6:0]         : {g,f,e,d,c,b,a}, active-low
//   mag_on              : magnetron enable, active-high
// Revision    : 1.0 - initial release
// ============================================================================
interface micro_waves_control_if;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic [9:0] keypad;
  logic [6:0] sec_ones_segs;
  logic [6:0] sec_tens_segs;
  logic [6:0] min_segs;
  logic       mag_on;

  modport master (
    output startn, stopn, clearn, door_closed, keypad,
    input  sec_ones_segs, sec_tens_segs, min_segs, mag_on
  );

  modport slave (
    input  startn, stopn, clearn, door_closed, keypad,
    output sec_ones_segs, sec_tens_segs, min_segs, mag_on
  );
endinterface
`default_nettype wire

// File: rtl/micro_waves_control.sv
`default_nettype none
// ============================================================================
// Module      : micro_waves_control
// Description : Microwave-oven controller. Cook time is entered as M:SS on a
//               one-hot keypad (shift-left entry), counts down once per
//               TICKS_PER_SEC clocks while cooking, and is shown on three
//               active-low 7-segment digits.
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : front-panel interface (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module micro_waves_control #(
  parameter int TICKS_PER_SEC = 100
) (
  input  wire                          clk,
  input  wire                          reset,
  micro_waves_control_if.slave         bus
);

  localparam int c_TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_TW-1:0] c_TICK_MAX = c_TW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COOK  = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_min;
  logic [3:0]      r_tens;
  logic [3:0]      r_ones;
  logic [c_TW-1:0] r_tick;
  logic            r_startn_q;
  logic            r_stopn_q;
  logic            r_clearn_q;
  logic [9:0]      r_key_q;

  logic            w_start_ev;
  logic            w_stop_ev;
  logic            w_clear_ev;
  logic            w_key_ev;
  logic [3:0]      w_key_digit;
  logic            w_time_zero;
  logic            w_last_sec;

  // Edge detection: one event per press, holding does not repeat.
  assign w_start_ev  = ~bus.startn & r_startn_q;
  assign w_stop_ev   = ~bus.stopn  & r_stopn_q;
  assign w_clear_ev  = ~bus.clearn & r_clearn_q;
  assign w_key_ev    = (bus.keypad != 10'd0) && (r_key_q == 10'd0);
  assign w_time_zero = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);
  assign w_last_sec  = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd1);

  // Scan from high to low so the lowest set bit is the one that sticks.
  always_comb begin
    w_key_digit = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (bus.keypad[i]) w_key_digit = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_min      <= 4'd0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_tick     <= '0;
      r_startn_q <= 1'b1;
      r_stopn_q  <= 1'b1;
      r_clearn_q <= 1'b1;
      r_key_q    <= 10'd0;
    end else begin
      r_startn_q <= bus.startn;
      r_stopn_q  <= bus.stopn;
      r_clearn_q <= bus.clearn;
      r_key_q    <= bus.keypad;

      if (w_clear_ev) begin
        r_state <= S_IDLE;
        r_min   <= 4'd0;
        r_tens  <= 4'd0;
        r_ones  <= 4'd0;
        r_tick  <= '0;
      end else if (r_state == S_COOK) begin
        if (!bus.door_closed || w_stop_ev) begin
          r_state <= S_PAUSE;
        end else if (r_tick == c_TICK_MAX) begin
          r_tick <= '0;
          // BCD decrement with borrow through tens (0..5) into minutes.
          if (r_ones != 4'd0) begin
            r_ones <= r_ones - 4'd1;
          end else begin
            r_ones <= 4'd9;
            if (r_tens != 4'd0) begin
              r_tens <= r_tens - 4'd1;
            end else begin
              r_tens <= 4'd5;
              r_min  <= r_min - 4'd1;
            end
          end
          if (w_last_sec) r_state <= S_IDLE;
        end else begin
          r_tick <= r_tick + 1'b1;
        end
      end else if (w_start_ev) begin
        // A start press outranks a simultaneous key even when it is refused.
        if (bus.door_closed && !w_time_zero) begin
          r_state <= S_COOK;
          r_tick  <= '0;
        end
      end else if (w_key_ev && (r_state == S_IDLE) && (r_ones <= 4'd5)) begin
        // Refusing the shift when ones > 5 keeps tens (and so minutes) in 0..5.
        r_min  <= r_tens;
        r_tens <= r_ones;
        r_ones <= w_key_digit;
      end
    end
  end

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h40;
      4'd1:    f_seg = 7'h79;
      4'd2:    f_seg = 7'h24;
      4'd3:    f_seg = 7'h30;
      4'd4:    f_seg = 7'h19;
      4'd5:    f_seg = 7'h12;
      4'd6:    f_seg = 7'h02;
      4'd7:    f_seg = 7'h78;
      4'd8:    f_seg = 7'h00;
      4'd9:    f_seg = 7'h10;
      default: f_seg = 7'h7F;
    endcase
  endfunction

  assign bus.min_segs      = f_seg(r_min);
  assign bus.sec_tens_segs = f_seg(r_tens);
  assign bus.sec_ones_segs = f_seg(r_ones);
  // Combinational so the magnetron drops in the same cycle the door opens.
  assign bus.mag_on        = (r_state == S_COOK) & bus.door_closed;

endmodule
`default_nettype wire

// File: tb/tb_micro_waves_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_waves_control
// Description : Self-checking bench for micro_waves_control. A reference
//               model tracks the cook time as total seconds and the oven
//               mode, and is compared with the displays and magnetron.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_waves_control;

  localparam int c_T = 100;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  micro_waves_control_if u_if ();

  micro_waves_control #(.TICKS_PER_SEC(c_T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = idle, 1 = cooking, 2 = paused.
  int m_mode;
  int m_secs;
  int m_tick;
  bit p_start, p_stop, p_clear;
  bit p_keyany;

  function automatic logic [6:0] seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    seg = (d >= 0 && d <= 9) ? tbl[d] : 7'h7F;
  endfunction

  task automatic model_step();
    bit st, sp, cl, ky;
    int k;
    if (reset) begin
      m_mode = 0; m_secs = 0; m_tick = 0;
      p_start = 1; p_stop = 1; p_clear = 1; p_keyany = 0;
      return;
    end
    st = !u_if.startn && p_start;
    sp = !u_if.stopn  && p_stop;
    cl = !u_if.clearn && p_clear;
    ky = (u_if.keypad != 0) && !p_keyany;
    k = 0;
    for (int i = 0; i < 10; i++) if (u_if.keypad[i]) begin k = i; break; end
    if (cl) begin
      m_mode = 0; m_secs = 0; m_tick = 0;
    end else if (m_mode == 1) begin
      if (!u_if.door_closed || sp) m_mode = 2;
      else begin
        m_tick++;
        if (m_tick == c_T) begin
          m_tick = 0;
          m_secs--;
          if (m_secs == 0) m_mode = 0;
        end
      end
    end else if (st) begin
      if (u_if.door_closed && m_secs != 0) begin m_mode = 1; m_tick = 0; end
    end else if (ky && m_mode == 0 && (m_secs % 10) <= 5) begin
      m_secs = ((m_secs % 60) / 10) * 60 + (m_secs % 10) * 10 + k;
    end
    p_start = u_if.startn; p_stop = u_if.stopn; p_clear = u_if.clearn;
    p_keyany = (u_if.keypad != 0);
  endtask

  // Advance n clocks; the model updates at each edge, checks happen at negedge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic press_key(input int d);
    u_if.keypad = 10'(1 << d); tick(1);
    u_if.keypad = 10'd0;       tick(1);
  endtask

  task automatic press_start(); u_if.startn = 0; tick(1); u_if.startn = 1; tick(1); endtask
  task automatic press_stop();  u_if.stopn  = 0; tick(1); u_if.stopn  = 1; tick(1); endtask
  task automatic press_clear(); u_if.clearn = 0; tick(1); u_if.clearn = 1; tick(1); endtask

  task automatic test_reset();
    reset = 1; tick(2); reset = 0; tick(1);
    n_tests++; if (u_if.min_segs !== 7'h40) begin n_fail++; $display("FAIL reset_min: got %h want 40", u_if.min_segs); end
    n_tests++; if (u_if.sec_tens_segs !== 7'h40) begin n_fail++; $display("FAIL reset_tens: got %h want 40", u_if.sec_tens_segs); end
    n_tests++; if (u_if.sec_ones_segs !== 7'h40) begin n_fail++; $display("FAIL reset_ones: got %h want 40", u_if.sec_ones_segs); end
    n_tests++; if (u_if.mag_on !== 1'b0) begin n_fail++; $display("FAIL reset_mag: got %b want 0", u_if.mag_on); end
  endtask

  task automatic test_entry();
    press_key(1); press_key(3); press_key(0);
    n_tests++;
    if ({u_if.min_segs, u_if.sec_tens_segs, u_if.sec_ones_segs} !== {7'h79, 7'h30, 7'h40}) begin
      n_fail++; $display("FAIL entry_130: got %h/%h/%h want 79/30/40",
                          u_if.min_segs, u_if.sec_tens_segs, u_if.sec_ones_segs);
    end
  endtask

  task automatic test_cook_short();
    press_clear(); press_key(2);
    u_if.startn = 0; tick(1);   // this edge enters cooking
    n_tests++; if (u_if.mag_on !== 1'b1) begin n_fail++; $display("FAIL short_mag_on: got %b want 1", u_if.mag_on); end
    u_if.startn = 1; tick(c_T - 1);
    n_tests++; if (u_if.sec_ones_segs !== 7'h24) begin n_fail++; $display("FAIL short_early: got %h want 24", u_if.sec_ones_segs); end
    tick(1);
    n_tests++; if (u_if.sec_ones_segs !== 7'h79) begin n_fail++; $display("FAIL short_first_dec: got %h want 79", u_if.sec_ones_segs); end
    tick(c_T);
    n_tests++; if (u_if.sec_ones_segs !== 7'h40 || u_if.mag_on !== 1'b0) begin
      n_fail++; $display("FAIL short_done: got ones=%h mag=%b want 40/0", u_if.sec_ones_segs, u_if.mag_on);
    end
    press_key(5);   // idle again, so entry is accepted
    n_tests++; if (u_if.sec_ones_segs !== 7'h12) begin n_fail++; $display("FAIL short_idle_entry: got %h want 12", u_if.sec_ones_segs); end
  endtask

  task automatic test_one_minute();
    press_clear(); press_key(1); press_key(0); press_key(0);
    u_if.startn = 0; tick(1); u_if.startn = 1; tick(c_T);
    n_tests++;
    if ({u_if.min_segs, u_if.sec_tens_segs, u_if.sec_ones_segs} !== {7'h40, 7'h12, 7'h10}) begin
      n_fail++; $display("FAIL minute_059: got %h/%h/%h want 40/12/10",
                          u_if.min_segs, u_if.sec_tens_segs, u_if.sec_ones_segs);
    end
  endtask

  task automatic test_door();
    tick(10);
    u_if.door_closed = 0; #1;
    n_tests++; if (u_if.mag_on !== 1'b0) begin n_fail++; $display("FAIL door_mag_drop: got %b want 0", u_if.mag_on); end
    @(negedge clk);
    tick(3 * c_T);
    n_tests++; if (u_if.sec_ones_segs !== 7'h10 || u_if.sec_tens_segs !== 7'h12) begin
      n_fail++; $display("FAIL door_hold: got %h/%h want 12/10", u_if.sec_tens_segs, u_if.sec_ones_segs);
    end
    u_if.door_closed = 1; tick(1);
    n_tests++; if (u_if.mag_on !== 1'b0) begin n_fail++; $display("FAIL door_paused: got %b want 0", u_if.mag_on); end
    press_start(); tick(c_T);
    n_tests++; if (u_if.mag_on !== 1'b1 || u_if.sec_ones_segs !== seg(m_secs % 10)) begin
      n_fail++; $display("FAIL door_resume: got mag=%b ones=%h want 1/%h", u_if.mag_on, u_if.sec_ones_segs, seg(m_secs % 10));
    end
  endtask

  task automatic test_stop_clear();
    press_stop(); tick(2 * c_T);
    n_tests++; if (u_if.mag_on !== 1'b0 || u_if.sec_ones_segs !== seg(m_secs % 10)) begin
      n_fail++; $display("FAIL stop_hold: got mag=%b ones=%h want 0/%h", u_if.mag_on, u_if.sec_ones_segs, seg(m_secs % 10));
    end
    press_clear();
    n_tests++; if ({u_if.min_segs, u_if.sec_tens_segs, u_if.sec_ones_segs} !== {7'h40, 7'h40, 7'h40}) begin
      n_fail++; $display("FAIL clear_zero: got %h/%h/%h want 40/40/40", u_if.min_segs, u_if.sec_tens_segs, u_if.sec_ones_segs);
    end
    press_start();
    n_tests++; if (u_if.mag_on !== 1'b0) begin n_fail++; $display("FAIL start_zero: got %b want 0", u_if.mag_on); end
    press_key(5); u_if.door_closed = 0; press_start(); u_if.door_closed = 1; tick(1);
    n_tests++; if (u_if.mag_on !== 1'b0) begin n_fail++; $display("FAIL start_door_open: got %b want 0", u_if.mag_on); end
  endtask

  task automatic test_entry_bounds();
    press_clear(); press_key(0); press_key(7); press_key(4);
    n_tests++; if (u_if.sec_tens_segs !== 7'h40 || u_if.sec_ones_segs !== 7'h78) begin
      n_fail++; $display("FAIL entry_reject: got %h/%h want 40/78", u_if.sec_tens_segs, u_if.sec_ones_segs);
    end
    press_clear(); u_if.keypad = 10'b0000001100; tick(1); u_if.keypad = 0; tick(1);
    n_tests++; if (u_if.sec_ones_segs !== 7'h24) begin n_fail++; $display("FAIL entry_lowest: got %h want 24", u_if.sec_ones_segs); end
    press_clear(); u_if.keypad = 10'b0000001000; tick(25); u_if.keypad = 0; tick(1);
    n_tests++; if (u_if.sec_tens_segs !== 7'h40 || u_if.sec_ones_segs !== 7'h30) begin
      n_fail++; $display("FAIL entry_hold: got %h/%h want 40/30", u_if.sec_tens_segs, u_if.sec_ones_segs);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 6000; c++) begin
      u_if.startn = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
      u_if.stopn  = ($urandom_range(0, 99) < 1) ? 1'b0 : 1'b1;
      u_if.clearn = ($urandom_range(0, 299) < 1) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 99) < 2) u_if.door_closed = ~u_if.door_closed;
      u_if.keypad = ($urandom_range(0, 99) < 15) ? 10'($urandom_range(1, 1023)) : 10'd0;
      reset = ($urandom_range(0, 999) < 1);
      tick(1);
      n_tests++;
      if (u_if.min_segs !== seg(m_secs / 60) || u_if.sec_tens_segs !== seg((m_secs % 60) / 10) ||
          u_if.sec_ones_segs !== seg(m_secs % 10) || u_if.mag_on !== (m_mode == 1 && u_if.door_closed)) begin
        n_fail++;
        $display("FAIL random_c%0d: got %h/%h/%h mag=%b want secs=%0d mode=%0d", c,
                 u_if.min_segs, u_if.sec_tens_segs, u_if.sec_ones_segs, u_if.mag_on, m_secs, m_mode);
      end
    end
    reset = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1;
    u_if.startn = 1; u_if.stopn = 1; u_if.clearn = 1;
    u_if.door_closed = 1; u_if.keypad = 10'd0;
    m_mode = 0; m_secs = 0; m_tick = 0;
    p_start = 1; p_stop = 1; p_clear = 1; p_keyany = 0;
    @(negedge clk);
    test_reset();
    test_entry();
    test_cook_short();
    test_one_minute();
    test_door();
    test_stop_clear();
    test_entry_bounds();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
